// File: rtl/phase_pkg.sv
// rtl/phase_pkg.sv - shared types and constants for the phase sequencer
package phase_pkg;

  localparam int PHASE_W            = 3;
  localparam int NUM_PHASES_DEFAULT = 5;
  localparam int INSN_W             = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } seq_state_t;

endpackage

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - exec button synchronizer, debouncer and rise pulse
module button_debounce #(
  parameter int DB_CYCLES = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  localparam logic [15:0] DB_LAST = 16'(DB_CYCLES - 1);

  logic        sync0;
  logic        sync1;
  logic        level;
  logic        level_d1;
  logic [15:0] db_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync0    <= 1'b0;
      sync1    <= 1'b0;
      level    <= 1'b0;
      level_d1 <= 1'b0;
      db_cnt   <= '0;
      pulse    <= 1'b0;
    end else begin
      sync0    <= btn;
      sync1    <= sync0;
      level_d1 <= level;
      pulse    <= level & ~level_d1;
      // Any cycle where the input agrees with the accepted level restarts the count
      if (sync1 == level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        level  <= sync1;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/phase_sequencer.sv
// rtl/phase_sequencer.sv - run/pause/halt phase sequencer with instruction counter
module phase_sequencer
  import phase_pkg::*;
#(
  parameter int DB_CYCLES  = 50000,
  parameter int NUM_PHASES = NUM_PHASES_DEFAULT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               exec_btn,
  input  logic               halt,
  output logic [PHASE_W-1:0] phase,
  output logic               exec_pulse,
  output logic               running,
  output logic [INSN_W-1:0]  insn_count
);

  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(NUM_PHASES - 1);

  seq_state_t          state_q;
  seq_state_t          state_d;
  logic [PHASE_W-1:0]  phase_q;
  logic [PHASE_W-1:0]  phase_d;
  logic [INSN_W-1:0]   insn_q;
  logic [INSN_W-1:0]   insn_d;

  button_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_debounce (
    .clock (clock),
    .reset (reset),
    .btn   (exec_btn),
    .pulse (exec_pulse)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      phase_q <= '0;
      insn_q  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      insn_q  <= insn_d;
    end
  end

  // Phase only moves while staying in RUN; halt outranks a coincident exec pulse
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    insn_d  = insn_q;
    unique case (state_q)
      IDLE: begin
        if (exec_pulse) state_d = RUN;
      end
      RUN: begin
        if (halt) begin
          state_d = HALTED;
        end else if (exec_pulse) begin
          state_d = IDLE;
        end else if (phase_q >= LAST_PHASE) begin
          phase_d = '0;
          insn_d  = insn_q + INSN_W'(1);
        end else begin
          phase_d = phase_q + PHASE_W'(1);
        end
      end
      HALTED: begin
        if (exec_pulse) begin
          state_d = RUN;
          phase_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign phase      = phase_q;
  assign running    = (state_q == RUN);
  assign insn_count = insn_q;

endmodule

// File: doc/phase_sequencer.md
PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 The block SHALL have parameter DB_CYCLES, default 50000: the number of consecutive stable cycles required to accept an exec_btn level change (range 1..65535).
REQ-002 The block SHALL have parameter NUM_PHASES, default 5: the number of phases per instruction, phase values 0..NUM_PHASES-1.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 exec_btn  input  1  raw, asynchronous, bouncing run/pause push-button.
REQ-006 halt  input  1  synchronous halt request from the datapath.
REQ-007 phase  output  3  current phase, consumed by the phase-strobe decoder.
REQ-008 exec_pulse  output  1  one-cycle clean exec event.
REQ-009 running  output  1  high while the state is RUN.
REQ-010 insn_count  output  16  number of completed instructions.

Function
REQ-011 exec_btn SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 The debounced level SHALL take a new value only after the synchronized input has differed from it for DB_CYCLES consecutive cycles; any bounce SHALL restart the count.
REQ-013 exec_pulse SHALL be high for exactly one cycle, in the cycle after the debounced level rises 0->1; a falling edge SHALL produce no pulse.
REQ-014 Latency from a stable exec_btn rise to exec_pulse SHALL be 2 + DB_CYCLES + 1 cycles, +/-1.
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN, HALTED.
REQ-016 In IDLE, exec_pulse SHALL move the FSM to RUN; phase SHALL keep its current value (resume).
REQ-017 In RUN, exec_pulse SHALL move the FSM to IDLE (pause) with phase frozen.
REQ-018 In RUN, halt=1 SHALL move the FSM to HALTED with phase frozen at its current value.
REQ-019 If halt and exec_pulse coincide in RUN, halt SHALL win and the FSM SHALL enter HALTED.
REQ-020 In HALTED, exec_pulse SHALL move the FSM to RUN and load phase to 0; halt is ignored in HALTED and IDLE.
REQ-021 In RUN with no transition, phase SHALL advance by 1 each cycle and wrap from NUM_PHASES-1 to 0.
REQ-022 phase SHALL never hold a value >= NUM_PHASES.
REQ-023 insn_count SHALL increment on each NUM_PHASES-1 -> 0 wrap in RUN and SHALL wrap modulo 2^16 (0xFFFF -> 0x0000).
REQ-024 A phase load to 0 on the HALTED->RUN transition SHALL NOT increment insn_count.
REQ-025 In a cycle where RUN is exited, phase and insn_count SHALL NOT advance.

Reset
REQ-026 reset=1 SHALL asynchronously force phase=0, FSM=IDLE, running=0, exec_pulse=0, insn_count=0, both synchronizer flops to 0, debounced level to 0 and debounce counter to 0.
REQ-027 A reset asserted mid-instruction SHALL abandon that instruction; no exec_pulse SHALL be generated by the reset itself.
REQ-028 After reset deasserts, a button already held down SHALL produce exactly one exec_pulse once it has been stable for DB_CYCLES cycles.

Structure
REQ-029 The package phase_pkg SHALL hold the FSM state type {IDLE, RUN, HALTED}, the NUM_PHASES default and the phase width constant (3).
REQ-030 The synchronizer, debounce counter and rising-edge pulse SHALL be implemented in one sub-module, button_debounce, instantiated once.

Verification (DB_CYCLES=4)
REQ-031 Scenario 1: reset, then exec_btn held 1 -> exactly one exec_pulse 7+/-1 cycles later; running=1; phase sequence 0,1,2,3,4,0; insn_count=1 after the wrap.
REQ-032 Scenario 2: exec_btn toggles every 2 cycles for 20 cycles, then stays 0 -> no exec_pulse and FSM stays IDLE.
REQ-033 Scenario 3: halt=1 in RUN at phase 2 -> HALTED with phase held at 2; next exec_pulse -> RUN with phase 0 and insn_count unchanged.
REQ-034 Scenario 4: halt and exec_pulse in the same cycle in RUN -> HALTED.
REQ-035 Scenario 5: preload insn_count=0xFFFF via 65535 wraps (or a force), then one more wrap -> insn_count=0x0000.
REQ-036 Scenario 6: reset asserted between clock edges at phase 3 in RUN -> phase=0, running=0 and insn_count=0 immediately, before the next clock edge.
